// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg
//   Shared definitions for the handshake arbiter slice.
//   - state_t     : arbiter FSM states, 2-bit encoding
//   - SYNC_STAGES : depth of the input synchroniser chains
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/hs_arbiter_sync2.sv
// sync2
//   Single-bit multi-flop synchroniser (SYNC_STAGES deep) for bringing an
//   asynchronous handshake signal into the clk domain. All flops reset to 0.
// Ports
//   clk  in  1  sampling clock
//   rstn in  1  asynchronous active-low reset
//   d    in  1  asynchronous input
//   q    out 1  synchronised output
module sync2
  import hs_arb_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/hs_arbiter.sv
// hs_arbiter
//   Round-robin arbiter sharing one downstream 4-phase req/ack channel between
//   N 4-phase clients. One client owns the channel for a full 4-phase cycle.
//   Build option: define HS_ARB_SYNC_EN to pass req[] and out_ack through
//   2-flop synchronisers (adds 2 cycles to every input-to-reaction latency).
// Ports
//   clk     in   1     system clock
//   rstn    in   1     asynchronous active-low reset
//   req     in   N     client requests, bit i = client i
//   ack     out  N     client acknowledges, one-hot or zero
//   out_req out  1     request to the shared channel
//   out_ack in   1     acknowledge from the shared channel
//   out_sel out  SELW  index of the granted client, stable while busy
//   busy    out  1     high whenever the FSM is not IDLE
module hs_arbiter
  import hs_arb_pkg::*;
#(
  parameter  int N    = 2,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  output logic            out_req,
  input  logic            out_ack,
  output logic [SELW-1:0] out_sel,
  output logic            busy
);

  logic [N-1:0] req_s;
  logic         out_ack_s;

`ifdef HS_ARB_SYNC_EN
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req_sync
      sync2 u_req_sync (.clk(clk), .rstn(rstn), .d(req[gi]), .q(req_s[gi]));
    end
  endgenerate
  sync2 u_ack_sync (.clk(clk), .rstn(rstn), .d(out_ack), .q(out_ack_s));
`else
  assign req_s     = req;
  assign out_ack_s = out_ack;
`endif

  // First requester at or after p, wrapping N-1 -> 0. Shifting instead of
  // indexing keeps the search free of out-of-range selects for any N.
  function automatic logic [SELW-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [SELW-1:0] p);
    logic [SELW-1:0] idx;
    logic [SELW-1:0] pick;
    logic [N-1:0]    r_shift;
    logic            found;
    idx   = p;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      r_shift = r >> idx;
      if (!found && r_shift[0]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == SELW'(N - 1)) ? '0 : idx + 1'b1;
    end
    return pick;
  endfunction

  state_t          state_reg,   state_next;
  logic [SELW-1:0] ptr_reg,     ptr_next;
  logic [SELW-1:0] sel_reg,     sel_next;
  logic [N-1:0]    ack_reg,     ack_next;
  logic            out_req_reg, out_req_next;
  logic            busy_reg,    busy_next;
  logic [N-1:0]    req_granted_shift;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      sel_reg     <= '0;
      ack_reg     <= '0;
      out_req_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
      ack_reg     <= ack_next;
      out_req_reg <= out_req_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    ptr_next          = ptr_reg;
    sel_next          = sel_reg;
    ack_next          = ack_reg;
    out_req_next      = out_req_reg;
    req_granted_shift = req_s >> sel_reg;
    case (state_reg)
      IDLE: begin
        if (|req_s) begin
          sel_next     = rr_pick(req_s, ptr_reg);
          out_req_next = 1'b1;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (out_ack_s) begin
          ack_next   = N'(1) << sel_reg;
          state_next = ACK;
        end
      end
      ACK: begin
        // Only the granted client's release matters; other req changes are ignored.
        if (!req_granted_shift[0]) begin
          out_req_next = 1'b0;
          state_next   = REL;
        end
      end
      REL: begin
        if (!out_ack_s) begin
          ack_next   = '0;
          ptr_next   = (sel_reg == SELW'(N - 1)) ? '0 : sel_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Registered so busy is a clean flop output rather than a state decode.
    busy_next = (state_next != IDLE);
  end

  assign ack     = ack_reg;
  assign out_req = out_req_reg;
  assign out_sel = sel_reg;
  assign busy    = busy_reg;

endmodule
